serial_add_sub: RTL and testbench

- Multi-cycle, bit-serial integer adder/subtractor for the CPU datapath.
- A single 1-bit full-adder cell computes one bit per clock, LSB first.
- The block owns the operand shift registers, the carry flop, the bit counter and the control FSM.
- Trades latency for area: one WIDTH-bit add or subtract in WIDTH cycles, with ALU-style flags for the flag register downstream.

---
 rtl/serial_add_sub.sv | 135 +++++++++++++
 tb/tb_serial_add_sub.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// ============================================================================
// Module   : serial_add_sub
// Purpose  : Bit-serial two's-complement adder/subtractor. A single gate-level
//            full-adder cell processes one bit per clock, LSB first, so a
//            WIDTH-bit add or subtract takes WIDTH cycles in RUN plus one
//            DONE cycle. ALU-style flags are produced for the flag register.
// Ports    : clk_i      - clock, all state changes on the rising edge
//            rst_i      - synchronous active-high reset
//            start_i    - request an operation (accepted in IDLE or DONE)
//            sub_i      - 0 = A+B, 1 = A-B, captured with start_i
//            a_i, b_i   - WIDTH-bit operands, captured with start_i
//            busy_o     - high while the operation is in RUN
//            done_o     - one-cycle pulse, result and flags are new
//            result_o   - sum/difference, held until the next completion
//            carry_o    - final carry out (subtract: 1 = no borrow)
//            overflow_o - signed overflow
//            zero_o     - result_o == 0
//            negative_o - result_o MSB
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sub #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             negative_o
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   acc;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  // Gate-level full-adder cell fed from the operand LSBs and the carry flop.
  logic             fa_a;
  logic             fa_b;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] acc_next;

  assign fa_a     = op_a[0];
  assign fa_b     = op_b[0];
  assign fa_sum   = fa_a ^ fa_b ^ carry;
  assign fa_cout  = (fa_a & fa_b) | (carry & (fa_a ^ fa_b));

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at position 0.
  assign acc_next = {fa_sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
      zero_o     <= 1'b0;
      negative_o <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            op_a   <= a_i;
            // Subtract is A + ~B + 1; the +1 enters through the carry flop.
            op_b   <= sub_i ? ~b_i : b_i;
            carry  <= sub_i;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end

        RUN: begin
          acc   <= acc_next;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            // On the last bit the carry flop still holds the carry into the
            // MSB, which is what signed overflow compares against.
            state      <= DONE;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            result_o   <= acc_next;
            carry_o    <= fa_cout;
            overflow_o <= carry ^ fa_cout;
            zero_o     <= ~|acc_next;
            negative_o <= fa_sum;
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none

module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 8-bit instance ----------------
  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, c8, v8, z8, n8;
  logic [7:0] res8;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .sub_i(sub8),
    .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8),
    .result_o(res8), .carry_o(c8), .overflow_o(v8),
    .zero_o(z8), .negative_o(n8)
  );

  // ---------------- 64-bit instance ----------------
  logic        start64 = 1'b0, sub64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        busy64, done64, c64, v64, z64, n64;
  logic [63:0] res64;

  serial_add_sub #(.WIDTH(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .start_i(start64), .sub_i(sub64),
    .a_i(a64), .b_i(b64), .busy_o(busy64), .done_o(done64),
    .result_o(res64), .carry_o(c64), .overflow_o(v64),
    .zero_o(z64), .negative_o(n64)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs one 8-bit operation; returns at the negedge where done8 should be high.
  // With hold=1, start8 stays high and the operand inputs change during RUN.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic hold);
    logic ok;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sub8 = s;
    @(posedge clk);
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (hold) begin a8 = 8'h11; b8 = 8'h22; end
      else start8 = 1'b0;
      if (busy8 !== 1'b1 || done8 !== 1'b0) ok = 1'b0;
    end
    chk("busy8_window", {63'd0, ok}, 64'd1);
    @(negedge clk);
    start8 = 1'b0;
    chk("done8_pulse", {63'd0, done8}, 64'd1);
    chk("busy8_in_done", {63'd0, busy8}, 64'd0);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       s;
    logic [7:0] r;
    logic       c, v, z, n;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            a      b      s     r      c     v     z     n
    vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy8", {63'd0, busy8}, 64'd0);
    chk("rst_done8", {63'd0, done8}, 64'd0);
    chk("rst_res8", {56'd0, res8}, 64'd0);
    chk("rst_flags8", {60'd0, c8, v8, z8, n8}, 64'd0);
    chk("rst_busy64", {63'd0, busy64}, 64'd0);
    chk("rst_res64", res64, 64'd0);
    rst = 1'b0;

    // ---- table-driven 8-bit vectors ----
    for (int i = 0; i < 9; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0);
      chk($sformatf("res8[%0d]", i), {56'd0, res8}, {56'd0, vecs[i].r});
      chk($sformatf("c8[%0d]", i), {63'd0, c8}, {63'd0, vecs[i].c});
      chk($sformatf("v8[%0d]", i), {63'd0, v8}, {63'd0, vecs[i].v});
      chk($sformatf("z8[%0d]", i), {63'd0, z8}, {63'd0, vecs[i].z});
      chk($sformatf("n8[%0d]", i), {63'd0, n8}, {63'd0, vecs[i].n});
    end

    // ---- start held high through RUN with changing operands ----
    op8(8'hFF, 8'h01, 1'b0, 1'b1);
    chk("hold_res8", {56'd0, res8}, 64'h00);
    chk("hold_cz8", {62'd0, c8, z8}, 64'd3);
    chk("hold_v8", {63'd0, v8}, 64'd0);
    begin
      logic extra;
      extra = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done8 !== 1'b0 || busy8 !== 1'b0 || res8 !== 8'h00) extra = 1'b1;
      end
      chk("hold_no_extra_done", {63'd0, extra}, 64'd0);
    end

    // ---- reset mid-RUN ----
    op8(8'h7F, 8'h01, 1'b0, 1'b0);   // leaves non-zero result and flags
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(posedge clk);        // third RUN edge is the one after E0+2
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy8", {63'd0, busy8}, 64'd0);
    chk("abort_done8", {63'd0, done8}, 64'd0);
    chk("abort_res8", {56'd0, res8}, 64'd0);
    chk("abort_flags8", {60'd0, c8, v8, z8, n8}, 64'd0);
    begin
      logic saw;
      saw = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done8 !== 1'b0 || busy8 !== 1'b0) saw = 1'b1;
      end
      chk("abort_no_done", {63'd0, saw}, 64'd0);
    end
    op8(8'h12, 8'h34, 1'b0, 1'b0);
    chk("after_abort_res8", {56'd0, res8}, 64'h46);

    // ---- simultaneous reset and start: reset wins ----
    @(negedge clk);
    rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_start_busy8", {63'd0, busy8}, 64'd0);
    chk("rst_start_res8", {56'd0, res8}, 64'd0);
    rst = 1'b0; start8 = 1'b0;
    @(negedge clk);
    chk("rst_start_idle8", {63'd0, busy8}, 64'd0);

    // ---- 64-bit back-to-back operations against a golden model ----
    begin
      logic [63:0] a, b, bb;
      logic        s, ev;
      logic [64:0] sum;
      int          cyc;
      bit          stop;
      stop = 0;
      @(negedge clk);
      for (int n = 0; n < 1000 && !stop; n++) begin
        case (n)
          0: begin a = 64'h8000_0000_0000_0000; b = 64'd1; s = 1'b1; end
          1: begin a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; s = 1'b0; end
          2: begin a = 64'd0; b = 64'd1; s = 1'b1; end
          3: begin a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; s = 1'b0; end
          default: begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            s = $urandom_range(0, 1);
          end
        endcase
        bb  = s ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {64'd0, s};
        ev  = (a[63] == bb[63]) && (sum[63] != a[63]);

        start64 = 1'b1; a64 = a; b64 = b; sub64 = s;
        @(posedge clk);
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
          start64 = 1'b0;
        end while (done64 !== 1'b1 && cyc < 80);

        chk($sformatf("spacing64[%0d]", n), 64'(cyc), 64'd65);
        if (done64 !== 1'b1) begin
          stop = 1;
        end else begin
          chk($sformatf("res64[%0d]", n), res64, sum[63:0]);
          chk($sformatf("flags64[%0d]", n), {60'd0, c64, v64, z64, n64},
              {60'd0, sum[64], ev, (sum[63:0] == 64'd0), sum[63]});
          if (n == 0) chk("v64_min_minus_1", {63'd0, v64}, 64'd1);
          if (n == 1) chk("cz64_all_ones_plus_1", {62'd0, c64, z64}, 64'd3);
        end
      end
      start64 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
